// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the 32x32 register file: round-robin arbitration of ALU and
// load writebacks onto the single write port, plus a pending-write scoreboard for decode.
module regfile_wb_scheduler #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic          flush,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  input  logic [AW-1:0] rs1_address,
  input  logic [AW-1:0] rs2_address,
  output logic          rs1_busy,
  output logic          rs2_busy,
  output logic          rf_write_enable,
  output logic [AW-1:0] rf_rd_address,
  output logic [DW-1:0] rf_rd_data
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  grant_e           last_grant_q, last_grant_d;
  logic             rf_we_q, rf_we_d;
  logic [AW-1:0]    rf_addr_q, rf_addr_d;
  logic [DW-1:0]    rf_data_q, rf_data_d;
  logic [NREGS-1:0] pending_q, pending_d;
  logic             alu_grant, mem_grant;

  // On a tie the source that did not win last time goes next, so neither waits over a cycle.
  always_comb begin
    alu_grant    = 1'b0;
    mem_grant    = 1'b0;
    last_grant_d = last_grant_q;
    if (reset_n) begin
      if (alu_valid && mem_valid) begin
        if (last_grant_q == GRANT_MEM) alu_grant = 1'b1;
        else                           mem_grant = 1'b1;
      end else begin
        alu_grant = alu_valid;
        mem_grant = mem_valid;
      end
    end
    if (alu_grant)      last_grant_d = GRANT_ALU;
    else if (mem_grant) last_grant_d = GRANT_MEM;
  end

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

  // x0 writes are accepted but never reach the port; address/data only move on real writes.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (alu_grant && (alu_rd != '0)) begin
      rf_we_d   = 1'b1;
      rf_addr_d = alu_rd;
      rf_data_d = alu_data;
    end else if (mem_grant && (mem_rd != '0)) begin
      rf_we_d   = 1'b1;
      rf_addr_d = mem_rd;
      rf_data_d = mem_data;
    end
  end

  // A new issue to a register beats a completing write to it on the same edge.
  always_comb begin
    pending_d = flush ? '0 : pending_q;
    if (!flush && rf_we_q && (rf_addr_q != '0)) pending_d[rf_addr_q] = 1'b0;
    if (issue_valid && (issue_rd != '0))        pending_d[issue_rd]  = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= GRANT_MEM;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      pending_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      pending_q    <= pending_d;
    end
  end

  assign rs1_busy        = (rs1_address != '0) && pending_q[rs1_address];
  assign rs2_busy        = (rs2_address != '0) && pending_q[rs2_address];
  assign rf_write_enable = rf_we_q;
  assign rf_rd_address   = rf_addr_q;
  assign rf_rd_data      = rf_data_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus random traffic,
// all checked against a rule-level model of grants, write port and pending bits.
module tb_regfile_wb_scheduler;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_rd = '0;
  logic          flush = 1'b0;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_rd = '0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_ready;
  logic          mem_valid = 1'b0;
  logic [AW-1:0] mem_rd = '0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_ready;
  logic [AW-1:0] rs1_address = '0;
  logic [AW-1:0] rs2_address = '0;
  logic          rs1_busy, rs2_busy;
  logic          rf_write_enable;
  logic [AW-1:0] rf_rd_address;
  logic [DW-1:0] rf_rd_data;

  regfile_wb_scheduler #(.NREGS(32), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .rs1_address(rs1_address), .rs2_address(rs2_address),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_write_enable(rf_write_enable), .rf_rd_address(rf_rd_address), .rf_rd_data(rf_rd_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } req_t;

  req_t          alu_q[$];
  req_t          mem_q[$];
  logic [AW-1:0] wr_log[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: pending set, who won last, and the write the port should show now.
  bit [31:0]     m_pending;
  bit            m_last_was_mem;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_pending      = '0;
    m_last_was_mem = 1'b1;
    m_we           = 1'b0;
    m_addr         = '0;
    m_data         = '0;
  endtask

  function automatic bit modelBusy(input logic [AW-1:0] rs);
    return (rs != 0) && m_pending[rs];
  endfunction

  // One clock cycle: drive requesters from their queues, check outputs, then advance the model.
  task automatic applyStimulus(input bit iv, input logic [AW-1:0] ird, input bit fl,
                               input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    bit        g_alu, g_mem;
    bit [31:0] np;
    issue_valid = iv;
    issue_rd    = ird;
    flush       = fl;
    rs1_address = r1;
    rs2_address = r2;
    alu_valid   = (alu_q.size() > 0);
    mem_valid   = (mem_q.size() > 0);
    if (alu_valid) begin alu_rd = alu_q[0].rd; alu_data = alu_q[0].data; end
    if (mem_valid) begin mem_rd = mem_q[0].rd; mem_data = mem_q[0].data; end
    #1;
    if (alu_valid && mem_valid) begin
      g_alu = m_last_was_mem;
      g_mem = !m_last_was_mem;
    end else begin
      g_alu = alu_valid;
      g_mem = mem_valid;
    end
    checkOutput("alu_ready", alu_ready, g_alu);
    checkOutput("mem_ready", mem_ready, g_mem);
    checkOutput("rs1_busy", rs1_busy, modelBusy(r1));
    checkOutput("rs2_busy", rs2_busy, modelBusy(r2));
    checkOutput("rf_write_enable", rf_write_enable, m_we);
    if (m_we) begin
      checkOutput("rf_rd_address", rf_rd_address, m_addr);
      checkOutput("rf_rd_data", rf_rd_data, m_data);
    end
    if (rf_write_enable) wr_log.push_back(rf_rd_address);
    @(posedge clock);
    np = fl ? 32'h0 : m_pending;
    if (!fl && m_we && m_addr != 0) np[m_addr] = 1'b0;
    if (iv && ird != 0) np[ird] = 1'b1;
    m_pending = np;
    if (g_alu) begin
      m_we = (alu_q[0].rd != 0);
      if (m_we) begin m_addr = alu_q[0].rd; m_data = alu_q[0].data; end
      m_last_was_mem = 1'b0;
      void'(alu_q.pop_front());
    end else if (g_mem) begin
      m_we = (mem_q[0].rd != 0);
      if (m_we) begin m_addr = mem_q[0].rd; m_data = mem_q[0].data; end
      m_last_was_mem = 1'b1;
      void'(mem_q.pop_front());
    end else begin
      m_we = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, r1, r2);
  endtask

  initial begin
    modelReset();

    // Held in reset with a request pending: nothing may be accepted or written.
    alu_valid   = 1'b1;
    alu_rd      = 5'd3;
    rs1_address = 5'd5;
    #2;
    checkOutput("reset_alu_ready", alu_ready, 1'b0);
    checkOutput("reset_rf_we", rf_write_enable, 1'b0);
    checkOutput("reset_rs1_busy", rs1_busy, 1'b0);
    checkOutput("reset_rf_addr", rf_rd_address, 5'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n   = 1'b1;
    alu_valid = 1'b0;

    applyStimulus(1'b1, 5'd5, 1'b0, 5'd5, 5'd0);
    rs1_address = 5'd5;
    #1;
    checkOutput("busy_x5_after_issue", rs1_busy, 1'b1);

    // Single ALU write to x7.
    applyStimulus(1'b1, 5'd7, 1'b0, 5'd7, 5'd5);
    alu_q.push_back('{rd: 5'd7, data: 32'hDEADBEEF});
    idle(3, 5'd7, 5'd5);

    // Load to x0 is accepted but never written; issue to x0 does not mark busy.
    mem_q.push_back('{rd: 5'd0, data: 32'h0000_1234});
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 5'd7);
    idle(1, 5'd0, 5'd0);

    // Contention: both sources busy, grants must alternate starting with ALU.
    wr_log.delete();
    alu_q.push_back('{rd: 5'd1, data: 32'h1111_0001});
    alu_q.push_back('{rd: 5'd2, data: 32'h2222_0002});
    mem_q.push_back('{rd: 5'd3, data: 32'h3333_0003});
    mem_q.push_back('{rd: 5'd4, data: 32'h4444_0004});
    idle(6, 5'd1, 5'd3);
    checkOutput("contention_count", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      checkOutput("contention_w0", wr_log[0], 5'd1);
      checkOutput("contention_w1", wr_log[1], 5'd3);
      checkOutput("contention_w2", wr_log[2], 5'd2);
      checkOutput("contention_w3", wr_log[3], 5'd4);
    end

    // Re-issue to x9 on the edge its old write retires: the new issue keeps it busy.
    applyStimulus(1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
    alu_q.push_back('{rd: 5'd9, data: 32'h0909_0909});
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd9, 5'd0);
    applyStimulus(1'b1, 5'd9, 1'b0, 5'd9, 5'd0);
    rs1_address = 5'd9;
    #1;
    checkOutput("collision_busy_x9", rs1_busy, 1'b1);

    // Flush together with an issue to x10 leaves only x10 pending.
    applyStimulus(1'b1, 5'd11, 1'b0, 5'd11, 5'd9);
    applyStimulus(1'b1, 5'd10, 1'b1, 5'd10, 5'd11);
    rs1_address = 5'd10;
    rs2_address = 5'd11;
    #1;
    checkOutput("flush_busy_x10", rs1_busy, 1'b1);
    checkOutput("flush_busy_x11", rs2_busy, 1'b0);
    rs2_address = 5'd9;
    #1;
    checkOutput("flush_busy_x9", rs2_busy, 1'b0);
    idle(2, 5'd10, 5'd9);

    // Random traffic from both producers with random issues, flushes and probes.
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (alu_q.size() == 0 && ($urandom % 3) == 0)
        alu_q.push_back('{rd: AW'($urandom), data: $urandom});
      if (mem_q.size() == 0 && ($urandom % 3) == 0)
        mem_q.push_back('{rd: AW'($urandom), data: $urandom});
      applyStimulus(($urandom % 4) == 0, AW'($urandom), ($urandom % 30) == 0,
                    AW'($urandom), AW'($urandom));
    end
    alu_q.delete();
    mem_q.delete();
    idle(2, 5'd0, 5'd0);

    // Asynchronous reset landing between edges while a write is on the port.
    applyStimulus(1'b1, 5'd12, 1'b0, 5'd12, 5'd0);
    alu_q.push_back('{rd: 5'd12, data: 32'hCAFE_F00D});
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd12, 5'd0);
    rs1_address = 5'd12;
    #1;
    checkOutput("pre_reset_rf_we", rf_write_enable, 1'b1);
    checkOutput("pre_reset_busy_x12", rs1_busy, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_rf_we", rf_write_enable, 1'b0);
    checkOutput("async_reset_busy_x12", rs1_busy, 1'b0);
    modelReset();
    @(negedge clock);
    reset_n = 1'b1;
    mem_q.push_back('{rd: 5'd13, data: 32'h1313_1313});
    alu_q.push_back('{rd: 5'd14, data: 32'h1414_1414});
    idle(4, 5'd13, 5'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sits between the execute/memory stages and the 32x32 register file's single write port.
- Arbitrates writeback requests from two producers (ALU result, memory load) onto that port, one write per cycle.
- Holds a 32-entry pending-write scoreboard so the decode stage can stall on read-after-write hazards.
- Registers the write port outputs; the register file itself is unchanged.

Parameters:
- NREGS, 32, number of architectural registers (x0 hardwired zero).
- AW, 5, register address width (log2 NREGS).
- DW, 32, data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode issued an instruction that will write issue_rd.
- issue_rd  in  AW  destination of issued instruction.
- flush  in  1  pipeline flush; clears all pending bits.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  AW  ALU destination.
- alu_data  in  DW  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- mem_valid  in  1  load writeback request.
- mem_rd  in  AW  load destination.
- mem_data  in  DW  load data.
- mem_ready  out  1  load request accepted this cycle.
- rs1_address  in  AW  decode source 1.
- rs2_address  in  AW  decode source 2.
- rs1_busy  out  1  rs1 has a pending write.
- rs2_busy  out  1  rs2 has a pending write.
- rf_write_enable  out  1  to regfile write_enable.
- rf_rd_address  out  AW  to regfile rd_address.
- rf_rd_data  out  DW  to regfile rd_data.

Behaviour:
- Reset (async, reset_n=0):
  - pending[31:0]=0, last_grant=MEM (so ALU wins the first tie).
  - rf_write_enable=0, rf_rd_address=0, rf_rd_data=0.
  - alu_ready=mem_ready=0 while reset is asserted.
- Reset mid-operation: in-flight registered write is discarded (rf_write_enable drops immediately); unaccepted requests are lost.
- Handshake:
  - Transfer occurs when valid && ready in the same cycle.
  - ready is combinational from the valid inputs and last_grant.
  - Requesters hold valid/rd/data stable until accepted.
- Arbitration, per cycle:
  - Only one valid: that source is granted.
  - Both valid: the source not equal to last_grant is granted (round-robin).
  - last_grant updates only on a grant.
  - Max wait for either source is 1 cycle.
- Write output: a grant in cycle N drives rf_write_enable=1 with the granted rd/data in cycle N+1 (registered). With no grant, rf_write_enable=0 in N+1; rf_rd_address/rf_rd_data hold their previous values.
- x0 writes: granted normally (ready=1), but rf_write_enable stays 0 and the scoreboard is untouched.
- Scoreboard:
  - Rising edge with rf_write_enable=1 and rf_rd_address!=0: clear pending[rf_rd_address].
  - Rising edge with issue_valid=1 and issue_rd!=0: set pending[issue_rd].
  - Same register set and cleared on one edge: set wins (newer producer).
  - flush=1: all bits cleared, except a simultaneous issue_valid, which is still applied. In-flight and requested writes are not cancelled.
  - Net effect: a write granted in cycle N is visible in the regfile and busy=0 from cycle N+2.
- Busy outputs:
  - rsX_busy = pending[rsX_address], combinational, no bypass.
  - Address 0 always reads 0.
- Multiple producers to one rd: a single pending bit; the first completing write clears it. Decode must not issue a second writer to a pending rd.

Test Plan:
- Reset: reset_n=0 with alu_valid=1 -> alu_ready=0, rf_write_enable=0, rs1_busy=0. Release, then issue_rd=5 -> rs1_address=5 gives rs1_busy=1 next cycle.
- Single ALU write: issue x7, alu_valid rd=7 data=0xDEADBEEF in cycle N -> alu_ready=1 in N; rf_write_enable=1, addr=7, data=0xDEADBEEF in N+1; busy(7)=1 through N+1, 0 in N+2.
- Contention: both valid for 4 cycles (ALU rd=1,2; MEM rd=3,4) -> grant order ALU,MEM,ALU,MEM; writes x1,x3,x2,x4 in consecutive cycles.
- x0: mem_valid rd=0 data=0x1234 -> mem_ready=1, rf_write_enable stays 0; issue_rd=0 leaves busy(0)=0.
- Set/clear collision: a pending x9 write on rf_write_enable coincides with issue_valid rd=9 -> busy(9) remains 1 afterwards. Flush with an issue to x10 -> only busy(10)=1.
- Async reset mid-write: assert reset_n low between edges while rf_write_enable=1 -> rf_write_enable=0 immediately, pending all zero.
